// File: rtl/mdio_pkg.sv
// Shared encodings for the MDIO management responder: FSM states, opcodes,
// register indices and the control-register reset value.
package mdio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StWdata,
        StRdata
    } mdio_state_e;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    localparam logic [15:0] BMCR_RST = 16'h1140;

endpackage

// File: rtl/mdio_slave_regs.sv
// 32 x 16 management register file; registers 1..3 are virtual (live status
// and fixed IDs) and ignore writes. BMCR soft-reset bit self-clears.
module mdio_slave_regs
    import mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1 = 16'h001C,
    parameter logic [15:0] PHY_ID2 = 16'hC916
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [15:0] stat_in_i,
    output logic [15:0] rd_data_o
);

    logic [15:0] mem_q [32];
    logic [15:0] mem_d [32];
    logic        wr_real;

    assign wr_real = wr_en_i && !(wr_addr_i inside {REG_BMSR, REG_ID1, REG_ID2});

    always_comb begin
        mem_d = mem_q;
        if (mem_q[0][15]) begin
            mem_d[0][15] = 1'b0;
        end
        if (wr_real) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= (i == 0) ? BMCR_RST : 16'h0000;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        unique case (rd_addr_i)
            REG_BMSR: rd_data_o = stat_in_i;
            REG_ID1:  rd_data_o = PHY_ID1;
            REG_ID2:  rd_data_o = PHY_ID2;
            default:  rd_data_o = mem_q[rd_addr_i];
        endcase
    end

endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: synchronises MDC/MDIO into the clk domain, decodes
// frames on MDC rising edges and drives read data on MDC falling edges.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'h04,
    parameter int unsigned PRE_LEN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h001C,
    parameter logic [15:0] PHY_ID2  = 16'hC916,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [15:0] stat_in,
    output logic        reg_wr_en,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    localparam int unsigned PreW = $clog2(PRE_LEN + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
    logic mdio_meta_q, mdio_sync_q;
    logic mdc_rise, mdc_fall, bit_in;

    mdio_state_e     state_q, state_d;
    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [14:0]     shift_q, shift_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      regad_q, regad_d;
    logic            addr_match_q, addr_match_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            mdio_o_q, mdio_o_d;
    logic            mdio_oe_q, mdio_oe_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;

    logic        commit, counting, timeout;
    logic [4:0]  addr5;
    logic [15:0] data16;
    logic [15:0] rd_data;

    assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign mdc_fall = ~mdc_sync_q & mdc_prev_q;
    assign bit_in   = mdio_sync_q;
    assign addr5    = {shift_q[3:0], bit_in};
    assign data16   = {shift_q, bit_in};

    // The watchdog also covers the gap between the last read bit and the
    // falling edge that releases the line.
    assign counting = (state_q != StIdle) || mdio_oe_q;
    assign timeout  = counting && !mdc_rise && (to_cnt_q == ToW'(TIMEOUT - 1));

    mdio_slave_regs #(
        .PHY_ID1 (PHY_ID1),
        .PHY_ID2 (PHY_ID2)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (commit),
        .wr_addr_i (regad_q),
        .wr_data_i (data16),
        .rd_addr_i (addr5),
        .stat_in_i (stat_in),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_meta_q   <= 1'b0;
            mdc_sync_q   <= 1'b0;
            mdc_prev_q   <= 1'b0;
            mdio_meta_q  <= 1'b0;
            mdio_sync_q  <= 1'b0;
            state_q      <= StIdle;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            op_q         <= '0;
            regad_q      <= '0;
            addr_match_q <= 1'b0;
            shadow_q     <= '0;
            to_cnt_q     <= '0;
            mdio_o_q     <= 1'b1;
            mdio_oe_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            mdc_meta_q   <= mdc;
            mdc_sync_q   <= mdc_meta_q;
            mdc_prev_q   <= mdc_sync_q;
            mdio_meta_q  <= mdio_i;
            mdio_sync_q  <= mdio_meta_q;
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            op_q         <= op_d;
            regad_q      <= regad_d;
            addr_match_q <= addr_match_d;
            shadow_q     <= shadow_d;
            to_cnt_q     <= to_cnt_d;
            mdio_o_q     <= mdio_o_d;
            mdio_oe_q    <= mdio_oe_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        op_d         = op_q;
        regad_d      = regad_q;
        addr_match_d = addr_match_q;
        shadow_d     = shadow_q;
        commit       = 1'b0;
        to_cnt_d     = (mdc_rise || !counting || timeout) ? '0 : to_cnt_q + 1'b1;

        if (timeout) begin
            state_d   = StIdle;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (mdc_rise) begin
            unique case (state_q)
                StIdle: begin
                    if (bit_in) begin
                        if (pre_cnt_q != PreW'(PRE_LEN)) begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end else begin
                        if (pre_cnt_q == PreW'(PRE_LEN)) begin
                            state_d = StStart;
                        end
                        pre_cnt_d = '0;
                    end
                end
                StStart: begin
                    state_d   = bit_in ? StOp : StIdle;
                    bit_cnt_d = '0;
                end
                StOp: begin
                    op_d = {op_q[0], bit_in};
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = ({op_q[0], bit_in} == OP_RD || {op_q[0], bit_in} == OP_WR)
                                    ? StPhyad : StIdle;
                    end
                end
                StPhyad: begin
                    shift_d = {shift_q[13:0], bit_in};
                    if (bit_cnt_q == 4'd4) begin
                        addr_match_d = (addr5 == PHY_ADDR);
                        bit_cnt_d    = '0;
                        state_d      = StRegad;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StRegad: begin
                    shift_d = {shift_q[13:0], bit_in};
                    if (bit_cnt_q == 4'd4) begin
                        regad_d   = addr5;
                        bit_cnt_d = '0;
                        state_d   = StTa;
                        if (op_q == OP_RD) begin
                            shadow_d = rd_data;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StTa: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = (op_q == OP_RD) ? StRdata : StWdata;
                    end
                end
                StWdata: begin
                    shift_d = {shift_q[13:0], bit_in};
                    if (bit_cnt_q == 4'd15) begin
                        commit    = addr_match_q;
                        bit_cnt_d = '0;
                        pre_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StRdata: begin
                    // Next bit to drive is always shadow_q[15].
                    shadow_d = {shadow_q[14:0], 1'b0};
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = '0;
                        pre_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        wr_en_d   = commit;
        wr_addr_d = commit ? regad_q : wr_addr_q;
        wr_data_d = commit ? data16 : wr_data_q;

        if (timeout) begin
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
        end else if (mdc_fall) begin
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            if (op_q == OP_RD && addr_match_q) begin
                if (state_q == StTa && bit_cnt_q == 4'd1) begin
                    mdio_o_d  = 1'b0;
                    mdio_oe_d = 1'b1;
                end else if (state_q == StRdata) begin
                    mdio_o_d  = shadow_q[15];
                    mdio_oe_d = 1'b1;
                end
            end
        end
    end

    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;

endmodule
